// File: rtl/nand_idelay_calib.sv
// Read-capture IODELAY calibration for the NAND interface: sweeps taps against a
// fixed training byte, locates the first passing window, and parks the tap at its centre.
module nand_idelay_calib #(
    parameter int unsigned      DQ_W          = 8,
    parameter int unsigned      TAP_W         = 5,
    parameter int unsigned      NUM_TAPS      = 32,
    parameter int unsigned      SETTLE_CYCLES = 8,
    parameter int unsigned      SAMPLE_CYCLES = 16,
    parameter logic [DQ_W-1:0]  PATTERN       = 8'hA5
) (
    input  logic             clk0,
    input  logic             rstn0,
    input  logic             cal_start,
    input  logic [DQ_W-1:0]  dq_in,
    output logic             dly_rst,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [TAP_W-1:0] tap_cnt,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W-1:0] win_end
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_CENTER = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pass, w_pass_nxt;
    logic             r_found, w_found_nxt;
    logic [TAP_W-1:0] r_tap, w_tap_nxt;
    logic [TAP_W-1:0] r_ws, w_ws_nxt;
    logic [TAP_W-1:0] r_we, w_we_nxt;
    logic             r_dly_rst, w_dly_rst_nxt;
    logic             r_dly_ce, w_dly_ce_nxt;
    logic             r_dly_inc, w_dly_inc_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    // Window centre: widened sum so win_start+win_end cannot wrap before the shift.
    logic [TAP_W:0]   w_sum;
    logic [TAP_W-1:0] w_target;
    assign w_sum    = {1'b0, r_ws} + {1'b0, r_we};
    assign w_target = w_sum[TAP_W:1];

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_found   <= 1'b0;
            r_tap     <= '0;
            r_ws      <= '0;
            r_we      <= '0;
            r_dly_rst <= 1'b0;
            r_dly_ce  <= 1'b0;
            r_dly_inc <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pass    <= w_pass_nxt;
            r_found   <= w_found_nxt;
            r_tap     <= w_tap_nxt;
            r_ws      <= w_ws_nxt;
            r_we      <= w_we_nxt;
            r_dly_rst <= w_dly_rst_nxt;
            r_dly_ce  <= w_dly_ce_nxt;
            r_dly_inc <= w_dly_inc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pass_nxt    = r_pass;
        w_found_nxt   = r_found;
        w_tap_nxt     = r_tap;
        w_ws_nxt      = r_ws;
        w_we_nxt      = r_we;
        w_dly_rst_nxt = 1'b0;
        w_dly_ce_nxt  = 1'b0;
        w_dly_inc_nxt = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_err_nxt     = r_err;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (cal_start) begin
                    w_dly_rst_nxt = 1'b1;
                    w_tap_nxt     = '0;
                    w_found_nxt   = 1'b0;
                    w_cnt_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_pass_nxt  = 1'b1;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                w_pass_nxt = r_pass & (dq_in == PATTERN);
                if (r_cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RECORD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RECORD: begin
                if (r_pass) begin
                    if (!r_found) begin
                        w_ws_nxt    = r_tap;
                        w_found_nxt = 1'b1;
                    end
                    w_we_nxt = r_tap;
                end
                // A failing tap after a pass closes the first window; later windows are ignored.
                if (!r_pass && r_found) begin
                    w_state_nxt = S_CENTER;
                end else if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
                    if (r_found || r_pass) begin
                        w_state_nxt = S_CENTER;
                    end else begin
                        w_dly_rst_nxt = 1'b1;
                        w_tap_nxt     = '0;
                        w_err_nxt     = 1'b1;
                        w_busy_nxt    = 1'b0;
                        w_state_nxt   = S_ERR;
                    end
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_dly_ce_nxt  = 1'b1;
                w_dly_inc_nxt = 1'b1;
                w_tap_nxt     = r_tap + TAP_W'(1);
                w_state_nxt   = S_SETTLE;
            end
            S_CENTER: begin
                // Decrement pulses are spaced by an idle cycle.
                if (r_tap > w_target) begin
                    if (!r_dly_ce) begin
                        w_dly_ce_nxt = 1'b1;
                        w_tap_nxt    = r_tap - TAP_W'(1);
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign dly_rst   = r_dly_rst;
    assign dly_ce    = r_dly_ce;
    assign dly_inc   = r_dly_inc;
    assign cal_busy  = r_busy;
    assign cal_done  = r_done;
    assign cal_err   = r_err;
    assign tap_cnt   = r_tap;
    assign win_start = r_ws;
    assign win_end   = r_we;

endmodule
